fetch_control: RTL and testbench

Fetch-stage controller of the RISC-V core, directly upstream of the instruction memory. Owns the program counter, drives `PC` into the instruction memory, captures the returned `INST_CODE` in the same cycle, and presents it to decode through an IF/ID register. Handles stall, redirect (branch/jump/flush) and halt-on-EBREAK with a small state machine.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/if_id_register.sv | 33 +++
 rtl/fetch_control.sv | 96 +++++++++
 tb/tb_fetch_control.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Decode and the instruction memory import this package as well.
package fetch_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] inst_t;

  localparam addr_t RESET_PC  = 32'h0000_0000;
  localparam inst_t NOP_INST  = 32'h0000_0013;  // addi x0,x0,0
  localparam inst_t HALT_INST = 32'h0010_0073;  // ebreak

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline register carrying PC, instruction and valid bit.
// Flush wins over load; with neither asserted the contents are held.
module if_id_register
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  flush,
  input  addr_t next_pc,
  input  inst_t next_inst,
  output addr_t if_pc,
  output inst_t if_inst,
  output logic  if_valid
);

  always_ff @(posedge clk) begin
    if (reset) begin
      if_pc    <= '0;
      if_inst  <= NOP_INST;
      if_valid <= 1'b0;
    end else if (flush) begin
      // PC is left alone so the bubble still reports the last issued address
      if_inst  <= NOP_INST;
      if_valid <= 1'b0;
    end else if (load) begin
      if_pc    <= next_pc;
      if_inst  <= next_inst;
      if_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage controller: program counter, next-PC mux, BOOT/RUN/HALT FSM
// and the IF/ID register feeding decode.
module fetch_control
  import fetch_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] PC,
  input  logic [31:0] INST_CODE,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INST,
  output logic        IF_VALID,
  output logic        HALTED,
  output logic        MISALIGN,
  output logic [31:0] FETCH_COUNT
);

  fetch_state_t state, state_next;
  addr_t        pc_q, pc_next;
  logic         misalign_q, misalign_next;
  logic [31:0]  count_q, count_next;
  logic         if_load, if_flush;
  addr_t        redirect_target;

  assign redirect_target = {REDIRECT_PC[31:2], 2'b00};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= BOOT;
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      state      <= state_next;
      pc_q       <= pc_next;
      misalign_q <= misalign_next;
      count_q    <= count_next;
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc_q;
    misalign_next = misalign_q;
    count_next    = count_q;
    if_load       = 1'b0;
    if_flush      = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        if (REDIRECT) begin
          pc_next  = redirect_target;
          if_flush = 1'b1;
          if (REDIRECT_PC[1:0] != 2'b00) misalign_next = 1'b1;
        end else if (!STALL) begin
          if_load    = 1'b1;
          count_next = count_q + 32'd1;
          if (INST_CODE == HALT_INST) state_next = HALT;
          else                        pc_next    = pc_q + 32'd4;
        end
      end
      HALT: begin
        if (REDIRECT) begin
          pc_next    = redirect_target;
          if_flush   = 1'b1;
          state_next = RUN;
          if (REDIRECT_PC[1:0] != 2'b00) misalign_next = 1'b1;
        end else if (!STALL) begin
          if_flush = 1'b1;
        end
      end
      default: state_next = BOOT;
    endcase
  end

  if_id_register u_if_id (
    .clk       (CLK),
    .reset     (RESET),
    .load      (if_load),
    .flush     (if_flush),
    .next_pc   (pc_q),
    .next_inst (INST_CODE),
    .if_pc     (IF_PC),
    .if_inst   (IF_INST),
    .if_valid  (IF_VALID)
  );

  assign PC          = pc_q;
  assign HALTED      = (state == HALT);
  assign MISALIGN    = misalign_q;
  assign FETCH_COUNT = count_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control with a small combinational instruction memory model.
module tb_fetch_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] inst_code;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_valid;
  logic        halted;
  logic        misalign;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [0:31];

  always #5 clk = ~clk;

  // Addresses beyond the modelled window read as a NOP
  always_comb inst_code = (pc[31:7] == 25'd0) ? mem[pc[6:2]] : 32'h0000_0013;

  fetch_control dut (
    .CLK         (clk),
    .RESET       (reset),
    .PC          (pc),
    .INST_CODE   (inst_code),
    .STALL       (stall),
    .REDIRECT    (redirect),
    .REDIRECT_PC (redirect_pc),
    .IF_PC       (if_pc),
    .IF_INST     (if_inst),
    .IF_VALID    (if_valid),
    .HALTED      (halted),
    .MISALIGN    (misalign),
    .FETCH_COUNT (fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc   [0:4];
    logic [31:0] exp_inst [0:4];
    logic        exp_val  [0:4];
    exp_pc   = '{32'h0, 32'h0, 32'h4, 32'h8, 32'hC};
    exp_inst = '{32'h13, 32'h13, 32'h00500093, 32'h00A00113, 32'h002081B3};
    exp_val  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    checks++;
    if (pc !== 32'h0 || if_pc !== 32'h0 || if_inst !== 32'h13 || if_valid !== 1'b0 ||
        halted !== 1'b0 || misalign !== 1'b0 || fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL reset_values pc=%h if_pc=%h if_inst=%h valid=%b halted=%b mis=%b cnt=%0d exp pc=0 if_pc=0 if_inst=13 others 0",
               pc, if_pc, if_inst, if_valid, halted, misalign, fetch_count);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      checks++;
      if (pc !== exp_pc[i] || if_inst !== exp_inst[i] || if_valid !== exp_val[i]) begin
        failures++;
        $display("FAIL boot_seq[%0d] pc=%h inst=%h valid=%b exp pc=%h inst=%h valid=%b",
                 i, pc, if_inst, if_valid, exp_pc[i], exp_inst[i], exp_val[i]);
      end
    end
    checks++;
    if (fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL boot_count got=%0d exp=3", fetch_count);
    end
  endtask

  task automatic test_boot_ignore();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    checks++;
    if (pc !== 32'h0 || if_valid !== 1'b0 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL boot_ignore pc=%h valid=%b mis=%b exp pc=0 valid=0 mis=0", pc, if_valid, misalign);
    end
    redirect = 1'b0; stall = 1'b0;
    step();
    checks++;
    if (pc !== 32'h4 || if_inst !== 32'h00500093 || if_valid !== 1'b1) begin
      failures++;
      $display("FAIL boot_first_run pc=%h inst=%h valid=%b exp pc=4 inst=00500093 valid=1", pc, if_inst, if_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(); step(); step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (pc !== 32'h8 || if_inst !== 32'h00A00113 || if_pc !== 32'h4 || fetch_count !== 32'd2) begin
        failures++;
        $display("FAIL stall_hold[%0d] pc=%h inst=%h if_pc=%h cnt=%0d exp pc=8 inst=00a00113 if_pc=4 cnt=2",
                 i, pc, if_inst, if_pc, fetch_count);
      end
    end
    stall = 1'b0;
    step();
    checks++;
    if (pc !== 32'hC || if_inst !== 32'h002081B3 || if_pc !== 32'h8 || fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL stall_resume pc=%h inst=%h if_pc=%h cnt=%0d exp pc=c inst=002081b3 if_pc=8 cnt=3",
               pc, if_inst, if_pc, fetch_count);
    end
  endtask

  // Continues from the state test_stall leaves behind (PC=0xC, IF_PC=8)
  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    checks++;
    if (pc !== 32'h40 || if_valid !== 1'b0 || if_inst !== 32'h13 || if_pc !== 32'h8 || fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL redirect_flush pc=%h valid=%b inst=%h if_pc=%h cnt=%0d exp pc=40 valid=0 inst=13 if_pc=8 cnt=3",
               pc, if_valid, if_inst, if_pc, fetch_count);
    end
    redirect = 1'b0; stall = 1'b0;
    step();
    checks++;
    if (if_pc !== 32'h40 || if_valid !== 1'b1 || if_inst !== 32'h00108093 || pc !== 32'h44 ||
        fetch_count !== 32'd4 || misalign !== 1'b0) begin
      failures++;
      $display("FAIL redirect_target if_pc=%h valid=%b inst=%h pc=%h cnt=%0d mis=%b exp if_pc=40 valid=1 inst=00108093 pc=44 cnt=4 mis=0",
               if_pc, if_valid, if_inst, pc, fetch_count, misalign);
    end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h46;
    step();
    checks++;
    if (pc !== 32'h44 || misalign !== 1'b1) begin
      failures++;
      $display("FAIL misalign_set pc=%h mis=%b exp pc=44 mis=1", pc, misalign);
    end
    redirect_pc = 32'h20;
    step();
    redirect = 1'b0;
    step();
    checks++;
    if (pc !== 32'h24 || misalign !== 1'b1) begin
      failures++;
      $display("FAIL misalign_sticky pc=%h mis=%b exp pc=24 mis=1", pc, misalign);
    end
  endtask

  task automatic test_halt();
    do_reset();
    checks++;
    if (misalign !== 1'b0) begin
      failures++;
      $display("FAIL misalign_reset got=%b exp=0", misalign);
    end
    step();
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    step();
    checks++;
    if (if_inst !== 32'h00100073 || if_valid !== 1'b1 || halted !== 1'b1 || pc !== 32'h10 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL halt_issue inst=%h valid=%b halted=%b pc=%h cnt=%0d exp inst=00100073 valid=1 halted=1 pc=10 cnt=1",
               if_inst, if_valid, halted, pc, fetch_count);
    end
    stall = 1'b1;
    step();
    checks++;
    if (if_inst !== 32'h00100073 || if_valid !== 1'b1 || halted !== 1'b1 || pc !== 32'h10) begin
      failures++;
      $display("FAIL halt_stall inst=%h valid=%b halted=%b pc=%h exp inst=00100073 valid=1 halted=1 pc=10",
               if_inst, if_valid, halted, pc);
    end
    stall = 1'b0;
    step(); step();
    checks++;
    if (if_inst !== 32'h13 || if_valid !== 1'b0 || halted !== 1'b1 || pc !== 32'h10 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL halt_frozen inst=%h valid=%b halted=%b pc=%h cnt=%0d exp inst=13 valid=0 halted=1 pc=10 cnt=1",
               if_inst, if_valid, halted, pc, fetch_count);
    end
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    checks++;
    if (halted !== 1'b0 || pc !== 32'h0 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_exit halted=%b pc=%h valid=%b exp halted=0 pc=0 valid=0", halted, pc, if_valid);
    end
    redirect = 1'b0;
    step();
    checks++;
    if (if_inst !== 32'h00500093 || if_valid !== 1'b1 || pc !== 32'h4 || fetch_count !== 32'd2) begin
      failures++;
      $display("FAIL halt_resume inst=%h valid=%b pc=%h cnt=%0d exp inst=00500093 valid=1 pc=4 cnt=2",
               if_inst, if_valid, pc, fetch_count);
    end
  endtask

  task automatic test_wrap_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    checks++;
    if (pc !== 32'hFFFF_FFFC) begin
      failures++;
      $display("FAIL wrap_target pc=%h exp=fffffffc", pc);
    end
    step();
    checks++;
    if (pc !== 32'h0 || if_pc !== 32'hFFFF_FFFC || if_valid !== 1'b1 || fetch_count !== 32'd3) begin
      failures++;
      $display("FAIL wrap_pc pc=%h if_pc=%h valid=%b cnt=%0d exp pc=0 if_pc=fffffffc valid=1 cnt=3",
               pc, if_pc, if_valid, fetch_count);
    end
    step();
    reset = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h47;
    step();
    checks++;
    if (pc !== 32'h0 || if_pc !== 32'h0 || if_inst !== 32'h13 || if_valid !== 1'b0 ||
        halted !== 1'b0 || misalign !== 1'b0 || fetch_count !== 32'h0) begin
      failures++;
      $display("FAIL midstream_reset pc=%h if_pc=%h if_inst=%h valid=%b halted=%b mis=%b cnt=%0d exp pc=0 if_pc=0 if_inst=13 others 0",
               pc, if_pc, if_inst, if_valid, halted, misalign, fetch_count);
    end
    reset = 1'b0; stall = 1'b0; redirect = 1'b0;
    step(); step();
    checks++;
    if (pc !== 32'h4 || if_inst !== 32'h00500093 || fetch_count !== 32'd1) begin
      failures++;
      $display("FAIL post_reset_run pc=%h inst=%h cnt=%0d exp pc=4 inst=00500093 cnt=1", pc, if_inst, fetch_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0000_0033;
    mem[0]  = 32'h0050_0093;
    mem[1]  = 32'h00A0_0113;
    mem[2]  = 32'h0020_81B3;
    mem[4]  = 32'h0010_0073;
    mem[16] = 32'h0010_8093;
    mem[17] = 32'h0021_0113;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    test_reset();
    test_boot_ignore();
    test_stall();
    test_redirect();
    test_misalign();
    test_halt();
    test_wrap_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
